// File: rtl/algn_md_splitter.sv
// Packs byte chunks into a two-word FIFO and issues MD RX transfers of the latched
// size at a running offset that wraps inside the bus word.
module algn_md_splitter #(
   parameter int ALGN_DATA_WIDTH   = 32,
   parameter int ALGN_OFFSET_WIDTH = $clog2(ALGN_DATA_WIDTH / 8),
   parameter int ALGN_SIZE_WIDTH   = $clog2(ALGN_DATA_WIDTH / 8) + 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [ALGN_SIZE_WIDTH-1:0]   cfg_size,
   input  logic [ALGN_OFFSET_WIDTH-1:0] cfg_offset,
   input  logic                         in_valid,
   input  logic [ALGN_DATA_WIDTH-1:0]   in_data,
   input  logic [ALGN_SIZE_WIDTH-1:0]   in_size,
   output logic                         in_ready,
   output logic                         in_drop,
   output logic                         md_rx_valid,
   output logic [ALGN_DATA_WIDTH-1:0]   md_rx_data,
   output logic [ALGN_OFFSET_WIDTH-1:0] md_rx_offset,
   output logic [ALGN_SIZE_WIDTH-1:0]   md_rx_size,
   input  logic                         md_rx_ready,
   input  logic                         md_rx_err,
   output logic                         cfg_err,
   output logic [7:0]                   err_cnt
);
   localparam int BW = ALGN_DATA_WIDTH / 8;
   localparam int BN = 2 * BW;
   localparam int OW = ALGN_OFFSET_WIDTH;
   localparam int SW = ALGN_SIZE_WIDTH;
   localparam int CW = $clog2(BN + 1);
   localparam int IW = $clog2(BN);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t                 r_state;
   logic [7:0]             r_buf [BN];
   logic [CW-1:0]          r_count;
   logic [SW-1:0]          r_size;
   logic [OW-1:0]          r_offset;
   logic                   r_valid;
   logic [ALGN_DATA_WIDTH-1:0] r_data;
   logic [OW-1:0]          r_md_off;
   logic [SW-1:0]          r_md_size;
   logic                   r_in_drop;
   logic                   r_cfg_err;
   logic [7:0]             r_err_cnt;

   logic [7:0]             w_buf_next [BN];
   logic [7:0]             w_in_byte [BW];
   logic [ALGN_DATA_WIDTH-1:0] w_ld_data;
   logic                   w_in_ready;
   logic                   w_accept;
   logic                   w_in_legal;
   logic                   w_cfg_latch;
   logic                   w_lat_legal;
   logic                   w_enough;
   logic                   w_done;
   logic                   w_load_idle;
   logic                   w_load;
   logic [CW-1:0]          w_push;
   logic [CW-1:0]          w_pop;
   logic [CW-1:0]          w_remain;
   logic [CW-1:0]          w_count_next;
   logic [OW-1:0]          w_off_adv;
   logic [OW-1:0]          w_ld_off;

   // Size must be a power of two no wider than the bus, offset aligned to it.
   function automatic logic f_cfg_legal(input logic [SW-1:0] s, input logic [OW-1:0] o);
      logic [SW-1:0] m;
      m = s - SW'(1);
      f_cfg_legal = (s != '0) && (s <= SW'(BW)) && ((s & m) == '0) && (({1'b0, o} & m) == '0);
   endfunction

   assign w_in_ready   = (r_count <= CW'(BW));
   assign w_accept     = in_valid & w_in_ready;
   assign w_in_legal   = (in_size != '0) && (in_size <= SW'(BW));
   assign w_push       = (w_accept && w_in_legal) ? CW'(in_size) : '0;

   assign w_cfg_latch  = (r_state == S_IDLE) && (r_count == '0);
   assign w_lat_legal  = f_cfg_legal(r_size, r_offset);
   assign w_enough     = (r_count >= CW'(r_size));
   assign w_done       = (r_state == S_BUSY) && md_rx_ready;
   assign w_load_idle  = (r_state == S_IDLE) && w_lat_legal && w_enough;
   assign w_load       = w_load_idle || (w_done && w_enough);
   assign w_pop        = w_load ? CW'(r_size) : '0;
   assign w_remain     = r_count - w_pop;
   assign w_count_next = w_remain + w_push;

   assign w_off_adv    = r_offset + r_size[OW-1:0];
   assign w_ld_off     = (r_state == S_BUSY) ? w_off_adv : r_offset;

   for (genvar gi = 0; gi < BW; gi++) begin : g_in
      assign w_in_byte[gi] = in_data[gi*8 +: 8];
   end

   // Head-of-buffer bytes placed at the load offset; everything else zero.
   for (genvar gi = 0; gi < BW; gi++) begin : g_ld
      logic [OW-1:0] w_rel;
      assign w_rel = OW'(gi) - w_ld_off;
      assign w_ld_data[gi*8 +: 8] =
         ((OW'(gi) >= w_ld_off) && ({1'b0, w_rel} < r_size)) ? r_buf[{1'b0, w_rel}] : 8'h00;
   end

   // Survivors shift down by the pop amount; pushed bytes land right after them.
   for (genvar gi = 0; gi < BN; gi++) begin : g_buf
      logic [CW-1:0] w_pos;
      logic [IW-1:0] w_src;
      logic [CW-1:0] w_rel;
      assign w_pos = CW'(gi);
      assign w_src = IW'(w_pos + w_pop);
      assign w_rel = w_pos - w_remain;
      assign w_buf_next[gi] = (w_pos < w_remain) ? r_buf[w_src] :
                              (w_rel < w_push)   ? w_in_byte[w_rel[OW-1:0]] :
                                                   r_buf[gi];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_buf     <= '{default: '0};
         r_count   <= '0;
         r_size    <= '0;
         r_offset  <= '0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_md_off  <= '0;
         r_md_size <= '0;
         r_in_drop <= 1'b0;
         r_cfg_err <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_buf     <= w_buf_next;
         r_count   <= w_count_next;
         r_in_drop <= w_accept & ~w_in_legal;

         if (w_cfg_latch) begin
            r_size    <= cfg_size;
            r_offset  <= cfg_offset;
            r_cfg_err <= ~f_cfg_legal(cfg_size, cfg_offset);
         end else if (w_done) begin
            r_offset  <= w_off_adv;
         end

         if (w_done && md_rx_err && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;

         if (w_load) begin
            r_state   <= S_BUSY;
            r_valid   <= 1'b1;
            r_data    <= w_ld_data;
            r_md_off  <= w_ld_off;
            r_md_size <= r_size;
         end else if (w_done) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
         end
      end
   end

   assign in_ready     = w_in_ready;
   assign in_drop      = r_in_drop;
   assign md_rx_valid  = r_valid;
   assign md_rx_data   = r_data;
   assign md_rx_offset = r_md_off;
   assign md_rx_size   = r_md_size;
   assign cfg_err      = r_cfg_err;
   assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_algn_md_splitter.sv
// Bench for algn_md_splitter: queue-based reference model checked every cycle,
// plus directed transfer logs compared against hand-computed values.
module tb_algn_md_splitter;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int OW = 2;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [SW-1:0] cfg_size = 3'd4;
   logic [OW-1:0] cfg_offset = 2'd0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [SW-1:0] in_size = '0;
   logic          in_ready;
   logic          in_drop;
   logic          md_rx_valid;
   logic [DW-1:0] md_rx_data;
   logic [OW-1:0] md_rx_offset;
   logic [SW-1:0] md_rx_size;
   logic          md_rx_ready = 1'b0;
   logic          md_rx_err = 1'b0;
   logic          cfg_err;
   logic [7:0]    err_cnt;

   algn_md_splitter #(
      .ALGN_DATA_WIDTH(DW), .ALGN_OFFSET_WIDTH(OW), .ALGN_SIZE_WIDTH(SW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .cfg_size(cfg_size), .cfg_offset(cfg_offset),
      .in_valid(in_valid), .in_data(in_data), .in_size(in_size), .in_ready(in_ready),
      .in_drop(in_drop), .md_rx_valid(md_rx_valid), .md_rx_data(md_rx_data),
      .md_rx_offset(md_rx_offset), .md_rx_size(md_rx_size), .md_rx_ready(md_rx_ready),
      .md_rx_err(md_rx_err), .cfg_err(cfg_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  q[$];
   bit          m_busy;
   logic [31:0] m_data;
   int          m_off, m_size, m_lsize, m_loff, m_err_cnt;
   bit          m_cfg_err, m_drop;

   function automatic bit legal(input int s, input int o);
      for (int p = 1; p <= BW; p = p * 2)
         if (s == p) return (o % s) == 0;
      return 1'b0;
   endfunction

   task automatic model_reset();
      q.delete();
      m_busy = 0; m_data = '0; m_off = 0; m_size = 0;
      m_lsize = 0; m_loff = 0; m_err_cnt = 0; m_cfg_err = 0; m_drop = 0;
   endtask

   task automatic model_load();
      m_data = '0;
      for (int i = 0; i < m_lsize; i++) m_data[8*(m_loff+i) +: 8] = q.pop_front();
      m_off = m_loff;
      m_size = m_lsize;
      m_busy = 1;
   endtask

   initial model_reset();

   always @(posedge clk) begin : model
      int cnt;
      bit acc;
      if (!reset_n) begin
         model_reset();
      end else begin
         cnt = q.size();
         acc = in_valid && (cnt <= BW);
         m_drop = acc && (in_size == 0 || in_size > BW);
         if (!m_busy) begin
            if (cnt == 0) begin
               m_lsize = int'(cfg_size);
               m_loff = int'(cfg_offset);
               m_cfg_err = !legal(m_lsize, m_loff);
            end else if (legal(m_lsize, m_loff) && cnt >= m_lsize) begin
               model_load();
            end
         end else if (md_rx_ready) begin
            if (md_rx_err && m_err_cnt < 255) m_err_cnt++;
            m_loff = (m_loff + m_lsize) % BW;
            if (cnt >= m_lsize) model_load();
            else m_busy = 0;
         end
         if (acc && !m_drop)
            for (int i = 0; i < int'(in_size); i++) q.push_back(in_data[8*i +: 8]);
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (reset_n) begin
         chk("valid", 32'(md_rx_valid), 32'(m_busy));
         if (m_busy) begin
            chk("data", md_rx_data, m_data);
            chk("offset", 32'(md_rx_offset), 32'(m_off));
            chk("size", 32'(md_rx_size), 32'(m_size));
         end
         chk("in_ready", 32'(in_ready), 32'(q.size() <= BW));
         chk("in_drop", 32'(in_drop), 32'(m_drop));
         chk("cfg_err", 32'(cfg_err), 32'(m_cfg_err));
         chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
      end
   end

   // ---------------- transfer log ----------------
   logic [31:0] log_d[$];
   int          log_o[$], log_s[$], log_c[$];
   logic [31:0] e_d[$];
   int          e_o[$], e_s[$];

   always @(posedge clk) begin
      if (reset_n && md_rx_valid && md_rx_ready) begin
         log_d.push_back(md_rx_data);
         log_o.push_back(int'(md_rx_offset));
         log_s.push_back(int'(md_rx_size));
         log_c.push_back(cyc);
      end
   end

   task automatic ex(input logic [31:0] d, input int o, input int s);
      e_d.push_back(d); e_o.push_back(o); e_s.push_back(s);
   endtask

   task automatic check_b2b(input string nm);
      for (int i = 1; i < log_c.size(); i++)
         chk($sformatf("%s_b2b%0d", nm, i), 32'(log_c[i] - log_c[i-1]), 32'd1);
   endtask

   task automatic check_log(input string nm);
      chk({nm, "_count"}, 32'(log_d.size()), 32'(e_d.size()));
      for (int i = 0; i < e_d.size() && i < log_d.size(); i++) begin
         chk($sformatf("%s_data%0d", nm, i), log_d[i], e_d[i]);
         chk($sformatf("%s_off%0d", nm, i), 32'(log_o[i]), 32'(e_o[i]));
         chk($sformatf("%s_size%0d", nm, i), 32'(log_s[i]), 32'(e_s[i]));
      end
      log_d.delete(); log_o.delete(); log_s.delete(); log_c.delete();
      e_d.delete(); e_o.delete(); e_s.delete();
   endtask

   // ---------------- drivers (called at a negedge) ----------------
   task automatic push(input logic [31:0] d, input int s);
      in_valid = 1'b1;
      in_data = d;
      in_size = SW'(s);
      for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
      chk("push_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic set_cfg(input int s, input int o);
      cfg_size = SW'(s);
      cfg_offset = OW'(o);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_values(input string nm);
      chk({nm, "_valid"}, 32'(md_rx_valid), 32'd0);
      chk({nm, "_data"}, md_rx_data, 32'd0);
      chk({nm, "_off"}, 32'(md_rx_offset), 32'd0);
      chk({nm, "_size"}, 32'(md_rx_size), 32'd0);
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({nm, "_in_drop"}, 32'(in_drop), 32'd0);
      chk({nm, "_cfg_err"}, 32'(cfg_err), 32'd0);
      chk({nm, "_err_cnt"}, 32'(err_cnt), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by %0t, required finish", $time);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      reset_n = 1'b1;
      md_rx_ready = 1'b1;

      // Full-word transfers, back to back.
      set_cfg(4, 0);
      push(32'h44332211, 4);
      push(32'h88776655, 4);
      repeat (8) @(negedge clk);
      ex(32'h44332211, 0, 4); ex(32'h88776655, 0, 4);
      check_b2b("t1");
      check_log("t1");

      // Half-word transfers starting at offset 2.
      set_cfg(2, 2);
      push(32'h44332211, 4);
      repeat (8) @(negedge clk);
      ex(32'h22110000, 2, 2); ex(32'h00004433, 0, 2);
      check_log("t2");

      // Single-byte transfers walking every offset, spanning two chunks.
      set_cfg(1, 0);
      push(32'h00CCBBAA, 3);
      push(32'h0000EEDD, 2);
      repeat (8) @(negedge clk);
      ex(32'h000000AA, 0, 1); ex(32'h0000BB00, 1, 1); ex(32'h00CC0000, 2, 1);
      ex(32'hDD000000, 3, 1); ex(32'h000000EE, 0, 1);
      check_b2b("t3");
      check_log("t3");

      // Stall with error asserted (ignored), then three errored completions.
      set_cfg(4, 0);
      md_rx_ready = 1'b0;
      md_rx_err = 1'b1;
      push(32'hA3A2A1A0, 4);
      push(32'hB3B2B1B0, 4);
      push(32'hC3C2C1C0, 4);
      chk("t4_full_ready", 32'(in_ready), 32'd0);
      chk("t4_valid", 32'(md_rx_valid), 32'd1);
      repeat (5) @(negedge clk);
      chk("t4_hold_data", md_rx_data, 32'hA3A2A1A0);
      chk("t4_err_hold", 32'(err_cnt), 32'd0);
      md_rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      md_rx_err = 1'b0;
      repeat (4) @(negedge clk);
      chk("t4_err_cnt", 32'(err_cnt), 32'd3);
      ex(32'hA3A2A1A0, 0, 4); ex(32'hB3B2B1B0, 0, 4); ex(32'hC3C2C1C0, 0, 4);
      check_log("t4");

      // Illegal chunk sizes are consumed and dropped.
      push(32'hDEADBEEF, 0);
      chk("drop0_pulse", 32'(in_drop), 32'd1);
      push(32'hDEADBEEF, 5);
      chk("drop5_pulse", 32'(in_drop), 32'd1);
      @(negedge clk);
      chk("drop_clear", 32'(in_drop), 32'd0);
      push(32'h76543210, 4);
      repeat (6) @(negedge clk);
      ex(32'h76543210, 0, 4);
      check_log("drop");

      // Misaligned config: nothing issued, buffer fills up.
      set_cfg(2, 1);
      chk("t5_cfg_err", 32'(cfg_err), 32'd1);
      push(32'h11223344, 4);
      push(32'h55667788, 4);
      chk("t5_full", 32'(in_ready), 32'd0);
      repeat (5) @(negedge clk);
      chk("t5_no_valid", 32'(md_rx_valid), 32'd0);
      check_log("t5");

      // Reset in the middle of a held transfer, then restart at cfg_offset.
      cfg_size = 3'd2;
      cfg_offset = 2'd2;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      md_rx_ready = 1'b0;
      repeat (2) @(negedge clk);
      push(32'h44332211, 4);
      @(negedge clk);
      chk("t6_valid", 32'(md_rx_valid), 32'd1);
      md_rx_err = 1'b1;
      md_rx_ready = 1'b1;
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_reset_values("t6_rst");
      md_rx_err = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      log_d.delete(); log_o.delete(); log_s.delete(); log_c.delete();
      repeat (2) @(negedge clk);
      push(32'hDDCCBBAA, 4);
      repeat (8) @(negedge clk);
      ex(32'hBBAA0000, 2, 2); ex(32'h0000DDCC, 0, 2);
      check_log("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
